// File: rtl/rf_port_arbiter_if.sv
// ============================================================================
//  Module   : rf_port_arbiter_if
//  Purpose  : Bundles both requester handshakes and the register-file access
//             port served by rf_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface rf_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Requester A (control unit)
    logic              a_req;
    logic              a_write;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_done;
    logic [DATA_W-1:0] a_rdata;

    // Requester B (debug/load port)
    logic              b_req;
    logic              b_write;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_done;
    logic [DATA_W-1:0] b_rdata;

    // Register file access port
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic              rf_re;
    logic [DATA_W-1:0] rf_rdata;

    logic              busy;

    // Requesters and the register file model drive this side
    modport master (
        output a_req, a_write, a_addr, a_wdata,
        output b_req, b_write, b_addr, b_wdata,
        output rf_rdata,
        input  a_gnt, a_done, a_rdata,
        input  b_gnt, b_done, b_rdata,
        input  rf_addr, rf_wdata, rf_we, rf_re, busy
    );

    // The arbiter drives this side
    modport slave (
        input  a_req, a_write, a_addr, a_wdata,
        input  b_req, b_write, b_addr, b_wdata,
        input  rf_rdata,
        output a_gnt, a_done, a_rdata,
        output b_gnt, b_done, b_rdata,
        output rf_addr, rf_wdata, rf_we, rf_re, busy
    );
endinterface

`default_nettype wire

// File: rtl/rf_port_arbiter.sv
// ============================================================================
//  Module   : rf_port_arbiter
//  Purpose  : Round-robin arbiter and one-transaction sequencer for the single
//             access port of the 32x32 register file (REG32 + DECODER_5x32).
//             Cycle N = GRANT (gnt pulse), N+1 = ACCESS (strobe),
//             then WAIT (reads only) and RESP (done pulse).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int RD_LAT     = 1,   // 1..7
    parameter int PROTECT_R0 = 1
) (
    input  wire logic        CLK,
    input  wire logic        RESET,
    rf_port_arbiter_if.slave bus
);

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GRANT  = 3'd1,
        ACCESS = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              owner_b;     // 1: current transaction belongs to B
    logic              last_b;      // 1: B was granted most recently
    logic              op_write;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic [2:0]        count;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    logic              any_req;
    logic              pick_b;
    logic              wr_blocked;

    // B wins when it is the only requester, or on a tie when A went last
    assign any_req    = bus.a_req | bus.b_req;
    assign pick_b     = bus.b_req & (~bus.a_req | ~last_b);
    assign wr_blocked = (PROTECT_R0 != 0) && (op_addr == '0);

    // State register; reset aborts any transaction in flight
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   state_nxt = ACCESS;
            ACCESS:  state_nxt = op_write ? RESP : WAIT;
            WAIT:    if (count == 3'd1) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arbitration pointer, latched request fields, latency counter, read data
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            owner_b   <= 1'b0;
            last_b    <= 1'b1;
            op_write  <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
            count     <= 3'd0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_b  <= pick_b;
                        last_b   <= pick_b;
                        op_write <= pick_b ? bus.b_write : bus.a_write;
                        op_addr  <= pick_b ? bus.b_addr  : bus.a_addr;
                        op_wdata <= pick_b ? bus.b_wdata : bus.a_wdata;
                    end
                end
                ACCESS: begin
                    if (!op_write) count <= LAT_LOAD;
                end
                WAIT: begin
                    count <= count - 3'd1;
                    if (count == 3'd1) begin
                        if (owner_b) b_rdata_q <= bus.rf_rdata;
                        else         a_rdata_q <= bus.rf_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from state so reset clears them immediately
    assign bus.busy     = (state != IDLE);
    assign bus.a_gnt    = (state == GRANT) & ~owner_b;
    assign bus.b_gnt    = (state == GRANT) &  owner_b;
    assign bus.a_done   = (state == RESP)  & ~owner_b;
    assign bus.b_done   = (state == RESP)  &  owner_b;
    assign bus.rf_we    = (state == ACCESS) &  op_write & ~wr_blocked;
    assign bus.rf_re    = (state == ACCESS) & ~op_write;
    assign bus.rf_addr  = (state == IDLE) ? '0 : op_addr;
    assign bus.rf_wdata = (state == IDLE) ? '0 : op_wdata;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_port_arbiter.sv
// ============================================================================
//  Module   : tb_rf_port_arbiter
//  Purpose  : Scoreboard bench for rf_port_arbiter: a register-file model on
//             one instance (RD_LAT=1, R0 protected) and a cycle-stamped read
//             source on a second instance (RD_LAT=7).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst7_n;

    rf_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus  ();
    rf_port_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus7 ();

    rf_port_arbiter #(.DATA_W(32), .ADDR_W(5), .RD_LAT(1), .PROTECT_R0(1)) u_dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    rf_port_arbiter #(.DATA_W(32), .ADDR_W(5), .RD_LAT(7), .PROTECT_R0(1)) u_dut7 (
        .CLK   (clk),
        .RESET (rst7_n),
        .bus   (bus7)
    );

    // Register file model: write on rf_we, read data valid one cycle after rf_re
    bit [31:0] rf_mem [32];
    bit [31:0] rd_pipe;
    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_addr] <= bus.rf_wdata;
        if (bus.rf_re) rd_pipe <= rf_mem[bus.rf_addr];
    end
    assign bus.rf_rdata = rd_pipe;

    // Read source for the long-latency instance: value changes every cycle
    bit [31:0] c7;
    always @(posedge clk) c7 <= c7 + 32'd1;
    assign bus7.rf_rdata = 32'hA500_0000 + c7;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          who;     // 0=A 1=B
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t      exp_q [$];
    exp_t      exp7_q [$];
    bit [31:0] ref_mem [32];
    bit [31:0] exp_last_a;
    bit [31:0] exp_last_b;

    // Monitor: pops the scoreboard on each done and tracks protocol violations
    int cyc = 0, gcyc_a = 0, gcyc_b = 0;
    int v_gnt = 0, v_done = 0, v_rw = 0, v_r0 = 0;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (bus.a_gnt && bus.b_gnt)   v_gnt++;
                if (bus.a_done && bus.b_done) v_done++;
                if (bus.rf_we && bus.rf_re)   v_rw++;
                if (bus.rf_we && bus.rf_addr == 5'd0) v_r0++;
                if (bus.a_gnt) gcyc_a = cyc;
                if (bus.b_gnt) gcyc_b = cyc;
                if (bus.a_done || bus.b_done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        bit   w;
                        e = exp_q.pop_front();
                        w = bus.b_done;
                        check("done_owner", {31'd0, w}, {31'd0, e.who});
                        check("done_rdata", w ? bus.b_rdata : bus.a_rdata, e.rdata);
                        check("done_latency", 32'(cyc - (w ? gcyc_b : gcyc_a)), 32'(e.lat));
                    end
                end
            end
        end
    end

    task automatic set_fields(input bit who, input bit req, input bit wr,
                              input logic [4:0] addr, input logic [31:0] data);
        if (who) begin
            bus.b_req = req; bus.b_write = wr; bus.b_addr = addr; bus.b_wdata = data;
        end else begin
            bus.a_req = req; bus.a_write = wr; bus.a_addr = addr; bus.a_wdata = data;
        end
    endtask

    // Record the expected outcome of one transaction and update the reference
    task automatic push_exp(input bit who, input bit wr, input logic [4:0] addr,
                            input logic [31:0] data);
        exp_t e;
        e.who = who;
        if (wr) begin
            if (addr != 5'd0) ref_mem[addr] = data;
            e.lat = 2;
        end else begin
            if (who) exp_last_b = ref_mem[addr];
            else     exp_last_a = ref_mem[addr];
            e.lat = 3;
        end
        e.rdata = who ? exp_last_b : exp_last_a;
        exp_q.push_back(e);
    endtask

    // One transaction on the main instance; drops req right after grant
    task automatic run_txn(input bit who, input bit wr, input logic [4:0] addr,
                           input logic [31:0] data);
        bit got;
        push_exp(who, wr, addr, data);
        set_fields(who, 1'b1, wr, addr, data);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = who ? bus.b_gnt : bus.a_gnt;
        end
        set_fields(who, 1'b0, wr, addr, data);
        if (!got) begin
            check("gnt_timeout", 32'd0, 32'd1);
            void'(exp_q.pop_back());
            return;
        end
        check("busy_at_gnt", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        check("rf_we", {31'd0, bus.rf_we}, {31'd0, wr && addr != 5'd0});
        check("rf_re", {31'd0, bus.rf_re}, {31'd0, !wr});
        check("rf_addr", {27'd0, bus.rf_addr}, {27'd0, addr});
        if (wr) check("rf_wdata", bus.rf_wdata, data);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            got = who ? bus.b_done : bus.a_done;
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        else      check("busy_at_done", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {25'd0, bus.busy, bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done,
                    bus.rf_we, bus.rf_re}, 32'd0);
        check("rst_rf_addr", {27'd0, bus.rf_addr}, 32'd0);
        check("rst_rf_wdata", bus.rf_wdata, 32'd0);
        check("rst_a_rdata", bus.a_rdata, 32'd0);
        check("rst_b_rdata", bus.b_rdata, 32'd0);
    endtask

    initial begin
        int na, nb;
        bit got;
        bit [31:0] v;
        int k;

        rst_n = 1'b0; rst7_n = 1'b0;
        set_fields(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        set_fields(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        bus7.a_req = 1'b0; bus7.a_write = 1'b0; bus7.a_addr = '0; bus7.a_wdata = '0;
        bus7.b_req = 1'b0; bus7.b_write = 1'b0; bus7.b_addr = '0; bus7.b_wdata = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        rst_n = 1'b1; rst7_n = 1'b1;
        @(negedge clk);

        // Single write, preload, read with latency 1, data hold
        run_txn(1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        run_txn(1'b1, 1'b1, 5'd7, 32'h12345678);
        run_txn(1'b1, 1'b0, 5'd7, 32'd0);
        check("a_rdata_hold_b_read", bus.a_rdata, exp_last_a);
        run_txn(1'b0, 1'b0, 5'd5, 32'd0);
        run_txn(1'b1, 1'b1, 5'd9, 32'h0BAD_F00D);
        check("a_rdata_hold_b_write", bus.a_rdata, 32'hDEADBEEF);

        // Protected R0
        run_txn(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
        run_txn(1'b0, 1'b0, 5'd0, 32'd0);

        // Contention from reset: expect A,B,A,B
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        exp_last_a = 32'd0; exp_last_b = 32'd0;
        push_exp(1'b0, 1'b1, 5'd10, 32'hA1A1_0010);
        push_exp(1'b1, 1'b1, 5'd11, 32'hB2B2_0011);
        push_exp(1'b0, 1'b0, 5'd10, 32'd0);
        push_exp(1'b1, 1'b0, 5'd11, 32'd0);
        set_fields(1'b0, 1'b1, 1'b1, 5'd10, 32'hA1A1_0010);
        set_fields(1'b1, 1'b1, 1'b1, 5'd11, 32'hB2B2_0011);
        na = 0; nb = 0;
        for (int i = 0; i < 80 && !(na == 2 && nb == 2 && exp_q.size() == 0); i++) begin
            @(negedge clk);
            if (bus.a_gnt) begin
                na++;
                if (na == 1) bus.a_write = 1'b0; else bus.a_req = 1'b0;
            end
            if (bus.b_gnt) begin
                nb++;
                if (nb == 1) bus.b_write = 1'b0; else bus.b_req = 1'b0;
            end
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        check("contention_a_grants", 32'(na), 32'd2);
        check("contention_b_grants", 32'(nb), 32'd2);

        // Reset during WAIT of a B read: aborted, no done, rdata cleared
        set_fields(1'b1, 1'b1, 1'b0, 5'd7, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = bus.b_gnt;
        end
        bus.b_req = 1'b0;
        check("abort_gnt", {31'd0, got}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("abort_in_wait", {31'd0, bus.busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_read");
        exp_last_a = 32'd0; exp_last_b = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b1, 1'b0, 5'd7, 32'd0);

        // Long latency read on the RD_LAT=7 instance
        bus7.b_req = 1'b1; bus7.b_write = 1'b0; bus7.b_addr = 5'd31;
        got = 1'b0;
        v = 32'd0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = bus7.b_gnt;
            v = c7;
        end
        bus7.b_req = 1'b0;
        check("lat7_gnt", {31'd0, got}, 32'd1);
        exp7_q.push_back('{who: 1'b1, rdata: 32'hA500_0000 + v + 32'd8, lat: 9});
        @(negedge clk);
        check("lat7_rf_re", {31'd0, bus7.rf_re}, 32'd1);
        check("lat7_rf_addr", {27'd0, bus7.rf_addr}, 32'd31);
        k = 1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            k++;
            got = bus7.b_done;
        end
        check("lat7_done_seen", {31'd0, got}, 32'd1);
        if (exp7_q.size() != 0) begin
            exp_t e;
            e = exp7_q.pop_front();
            check("lat7_latency", 32'(k), 32'(e.lat));
            check("lat7_rdata", bus7.b_rdata, e.rdata);
        end
        check("lat7_a_rdata", bus7.a_rdata, 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("gnt_overlap", 32'(v_gnt), 32'd0);
        check("done_overlap", 32'(v_done), 32'd0);
        check("we_re_overlap", 32'(v_rw), 32'd0);
        check("r0_write_strobe", 32'(v_r0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
